// File: rtl/mdu.sv
// Multiply/divide unit: runs mult/multu/div/divu over a fixed cycle count,
// holds the architectural HI/LO registers and services mthi/mtlo writes.
// The full 64-bit result is formed at launch and parked in pending registers;
// HI/LO only change on the completion edge, so nothing is visible early.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDUop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] p_hi, p_hi_nxt;
  logic [31:0] p_lo, p_lo_nxt;
  logic        p_wr, p_wr_nxt;
  logic        busy_nxt;
  logic [31:0] hi_nxt, lo_nxt;
  logic [63:0] res;

  // 64-bit product; the signed form sign-extends both operands first.
  function automatic logic [63:0] mul_res(input logic is_signed,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sp;
    logic        [63:0] up;
    sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    up = {32'd0, a} * {32'd0, b};
    return is_signed ? $unsigned(sp) : up;
  endfunction

  // {remainder, quotient}; signed form truncates toward zero and gives the
  // remainder the dividend's sign. The one overflowing case is pinned down
  // explicitly. A zero divisor returns zero, but that result is never committed.
  function automatic logic [63:0] div_res(input logic is_signed,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    logic [63:0] r;
    sa = a;
    sb = b;
    r  = '0;
    if (b != 32'd0) begin
      if (is_signed) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r = {32'd0, 32'h8000_0000};
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {$unsigned(sr), $unsigned(sq)};
        end
      end else begin
        r = {a % b, a / b};
      end
    end
    return r;
  endfunction

  // Result selection for the op being launched this cycle.
  always_comb begin
    res = '0;
    case (MDUop)
      3'd0:    res = mul_res(1'b1, A, B);
      3'd1:    res = mul_res(1'b0, A, B);
      3'd2:    res = div_res(1'b1, A, B);
      3'd3:    res = div_res(1'b0, A, B);
      default: res = '0;
    endcase
  end

  // Next-state, countdown and HI/LO update decisions.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    p_hi_nxt  = p_hi;
    p_lo_nxt  = p_lo;
    p_wr_nxt  = p_wr;
    busy_nxt  = busy;
    hi_nxt    = HI;
    lo_nxt    = LO;
    case (state)
      IDLE: begin
        if (start) begin
          case (MDUop)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              p_hi_nxt  = res[63:32];
              p_lo_nxt  = res[31:0];
              // A zero divisor still occupies the unit but commits nothing.
              p_wr_nxt  = !(MDUop[1] && (B == 32'd0));
              cnt_nxt   = MDUop[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
              busy_nxt  = 1'b1;
              state_nxt = RUN;
            end
            3'd4:    hi_nxt = A;
            3'd5:    lo_nxt = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          if (p_wr) begin
            hi_nxt = p_hi;
            lo_nxt = p_lo;
          end
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and architectural registers; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      p_wr  <= 1'b0;
      busy  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      p_hi  <= p_hi_nxt;
      p_lo  <= p_lo_nxt;
      p_wr  <= p_wr_nxt;
      busy  <= busy_nxt;
      HI    <= hi_nxt;
      LO    <= lo_nxt;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: stimulus issues ops and queues the expected response from
// an arithmetic reference model; a monitor checks busy length, HI/LO hold
// during the run, and the committed HI/LO at completion.
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  typedef longint unsigned u64_t;

  typedef struct {
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    logic [31:0] new_hi;
    logic [31:0] new_lo;
    int          n;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  MDUop;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;

  exp_t        q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  bit          flush = 1'b0;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .MDUop(MDUop),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint p, qq, rr;
    u64_t   up;
    e.old_hi = m_hi;
    e.old_lo = m_lo;
    e.new_hi = m_hi;
    e.new_lo = m_lo;
    e.n      = 0;
    case (op)
      3'd0: begin
        p = longint'(signed'(a)) * longint'(signed'(b));
        e.new_hi = p[63:32]; e.new_lo = p[31:0]; e.n = MC;
      end
      3'd1: begin
        up = u64_t'(a) * u64_t'(b);
        e.new_hi = up[63:32]; e.new_lo = up[31:0]; e.n = MC;
      end
      3'd2: begin
        e.n = DC;
        if (b != 0) begin
          qq = longint'(signed'(a)) / longint'(signed'(b));
          rr = longint'(signed'(a)) % longint'(signed'(b));
          e.new_lo = qq[31:0]; e.new_hi = rr[31:0];
        end
      end
      3'd3: begin
        e.n = DC;
        if (b != 0) begin
          e.new_lo = a / b; e.new_hi = a % b;
        end
      end
      3'd4: e.new_hi = a;
      3'd5: e.new_lo = a;
      default: ;
    endcase
    return e;
  endfunction

  // Issue one op from IDLE, queue its expectation, then wait until idle again.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   k;
    e = model(op, a, b);
    m_hi = e.new_hi;
    m_lo = e.new_lo;
    q.push_back(e);
    start = 1'b1; MDUop = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy !== 1'b0 && k < 40);
    if (busy !== 1'b0) chk("idle_timeout", {31'd0, busy}, 32'd0);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: one queued expectation per accepted op, checked cycle by cycle.
  initial begin
    exp_t cur;
    bit   active;
    int   cyc;
    active = 1'b0;
    cyc    = 0;
    forever begin
      @(negedge clk);
      if (flush) begin
        active = 1'b0;
        flush  = 1'b0;
      end else begin
        if (!active && q.size() > 0) begin
          cur    = q.pop_front();
          active = 1'b1;
          cyc    = 0;
        end
        if (active) begin
          cyc++;
          if (cyc <= cur.n) begin
            chk("busy_run", {31'd0, busy}, 32'd1);
            chk("hi_hold", HI, cur.old_hi);
            chk("lo_hold", LO, cur.old_lo);
          end else begin
            chk("busy_done", {31'd0, busy}, 32'd0);
            chk("hi_result", HI, cur.new_hi);
            chk("lo_result", LO, cur.new_lo);
            active = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    reset = 1'b1; start = 1'b0; MDUop = 3'd0; A = '0; B = '0;
    #3;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;

    // Directed cases.
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    chk("dir_mult_hi", HI, 32'hFFFF_FFFF);
    chk("dir_mult_lo", LO, 32'hFFFF_FFEB);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    chk("dir_multu_hi", HI, 32'h0000_0001);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("dir_div_lo", LO, 32'hFFFF_FFFD);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("dir_divovf_lo", LO, 32'h8000_0000);
    chk("dir_divovf_hi", HI, 32'd0);
    issue(3'd4, 32'h1234_5678, 32'd0);
    issue(3'd5, 32'h9ABC_DEF0, 32'd0);
    issue(3'd3, 32'd7, 32'd0);
    chk("dir_div0_hi", HI, 32'h1234_5678);
    chk("dir_div0_lo", LO, 32'h9ABC_DEF0);
    issue(3'd6, 32'h5555_5555, 32'd1);

    // Start during RUN must be ignored, and operand changes must not leak.
    e = model(3'd1, 32'd3, 32'd4);
    m_hi = e.new_hi; m_lo = e.new_lo;
    q.push_back(e);
    start = 1'b1; MDUop = 3'd1; A = 32'd3; B = 32'd4;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; MDUop = 3'd5; A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D;
    @(posedge clk); #1 start = 1'b0; A = 32'h1111_1111;
    wait_idle();
    chk("dir_ign_lo", LO, 32'h0000_000C);

    // Reset in the middle of a divide.
    e = model(3'd2, 32'd100, 32'd7);
    q.push_back(e);
    start = 1'b1; MDUop = 3'd2; A = 32'd100; B = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #1 flush = 1'b1; reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk); #1 reset = 1'b0;
    @(negedge clk); #1;
    issue(3'd0, 32'd2, 32'd3);
    chk("postrst_lo", LO, 32'd6);
    chk("postrst_hi", HI, 32'd0);

    // Randomized mix of all opcodes.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra, rb;
      logic [2:0]  op;
      op = 3'($urandom_range(0, 7));
      ra = pick();
      rb = ($urandom_range(0, 9) == 0) ? 32'd0 : pick();
      issue(op, ra, rb);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the MIPS datapath, sitting beside the ALU in the execute stage. It takes the two GRF read operands (rs, rt) and runs mult/multu/div/divu over a fixed number of cycles, raising `busy` while it works. It also handles mthi/mtlo writes and holds the architectural HI/LO registers that feed the register write-back mux (mfhi/mflo). The controller uses `busy` to stall any instruction that needs the unit.

## Interface
Parameters:
- MULT_CYCLES, 5, cycles from mult/multu launch to result; legal range 1..15
- DIV_CYCLES, 10, cycles from div/divu launch to result; legal range 1..15

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  launch request, sampled on rising edge
- MDUop  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6/7 reserved
- A  input  32  rs operand (GRF RD1)
- B  input  32  rt operand (GRF RD2)
- busy  output  1  operation in flight (registered)
- HI  output  32  HI register (registered)
- LO  output  32  LO register (registered)

## Operation
- Reset values: busy=0, HI=0, LO=0, state=IDLE, counter=0, pending result regs=0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; a cycle counter counts down.
- IDLE with start=1 and MDUop in 0..3:
  - A and B are captured.
  - The 64-bit result is computed into pending regs {pHI,pLO}.
  - Counter is loaded with MULT_CYCLES (ops 0-1) or DIV_CYCLES (ops 2-3).
  - State goes to RUN.
- IDLE with start=1 and MDUop=4: HI<=A. With MDUop=5: LO<=A. Takes one edge; state stays IDLE; busy stays 0.
- start=1 with MDUop 6/7: ignored, no state change.
- RUN: counter decrements each edge. On the edge where counter==1:
  - HI<=pHI and LO<=pLO.
  - busy<=0, state<=IDLE.
- start while in RUN (any MDUop): ignored. The controller is responsible for stalling so this never carries a real instruction.
- Arithmetic rules:
  - mult: signed 32x32 product → {HI,LO}.
  - multu: unsigned 32x32 product → {HI,LO}.
  - div: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend (A).
  - div with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient in LO, remainder in HI.
  - Divide by zero (B==0, div or divu): the op still occupies DIV_CYCLES cycles with busy=1; at completion HI and LO keep their prior values.
- HI/LO outputs keep their old values for the whole RUN period. Results are never visible early.

## Timing
- Launch edge k (start sampled high in IDLE): busy=1 from after edge k.
- Completion edge k+N (N = MULT_CYCLES or DIV_CYCLES): HI/LO update and busy returns to 0.
- busy is therefore high for exactly N clock cycles.
- A new start may be accepted on edge k+N+1, i.e. the first edge on which busy is sampled 0. There is no same-edge back-to-back launch at completion.
- mthi/mtlo: HI/LO visible one edge after start; busy never asserts.
- Operands are captured only at the launch edge; A/B changes during RUN have no effect.
- reset asserted mid-RUN: busy, HI, LO drop to 0 asynchronously and the pending result is discarded. After reset deasserts, the first start behaves as if from power-up.
- Outputs do not depend combinationally on any input.

## Test plan
- Reset, then start, MDUop=0, A=0xFFFFFFFD (-3), B=7 → busy=1 for exactly 5 cycles; after the 5th edge HI=0xFFFFFFFF, LO=0xFFFFFFEB, busy=0; HI/LO read 0 throughout busy.
- start, MDUop=1, A=0xFFFFFFFF, B=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- start, MDUop=2, A=0xFFFFFFF9 (-7), B=2 → busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then MDUop=2 with A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- MDUop=4 with A=0x12345678, then MDUop=5 with A=0x9ABCDEF0 → HI=0x12345678 and LO=0x9ABCDEF0, each one edge after start, busy never high. Then divu A=7, B=0 → busy for 10 cycles, HI/LO unchanged.
- Launch multu A=3, B=4; at cycle 2 of busy assert start with MDUop=5, A=0xDEADBEEF, and change A/B → ignored; final HI=0, LO=0x0000000C.
- Launch div, assert reset at cycle 4 of busy → busy/HI/LO=0 immediately. Release reset and launch mult A=2, B=3 → LO=6 after 5 cycles, with no stale division result appearing.
